// File: rtl/wb2ahb.sv
// wb2ahb: Wishbone classic slave to AHB master bridge, one SINGLE NONSEQ transfer per WB cycle
//   WB  in : clk_i, rst_i, cyc_i, stb_i, we_i, adr_i, sel_i, dat_i
//   WB  out: dat_o, ack_o, err_o
//   AHB out: hbusreq, haddr, htrans, hwrite, hsize, hburst, hprot, hwdata
//   AHB in : hgrant, hrdata, hready, hresp
module wb2ahb #(
    parameter int AWIDTH = 16,
    parameter int DWIDTH = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              cyc_i,
    input  logic              stb_i,
    input  logic              we_i,
    input  logic [AWIDTH-1:0] adr_i,
    input  logic [3:0]        sel_i,
    input  logic [DWIDTH-1:0] dat_i,
    output logic [DWIDTH-1:0] dat_o,
    output logic              ack_o,
    output logic              err_o,
    output logic              hbusreq,
    input  logic              hgrant,
    output logic [AWIDTH-1:0] haddr,
    output logic [1:0]        htrans,
    output logic              hwrite,
    output logic [2:0]        hsize,
    output logic [2:0]        hburst,
    output logic [3:0]        hprot,
    output logic [DWIDTH-1:0] hwdata,
    input  logic [DWIDTH-1:0] hrdata,
    input  logic              hready,
    input  logic [1:0]        hresp
);
    typedef enum logic [2:0] {IDLE, REQ, ADDR, DATA, ACK, ERR} state_t;
    state_t            state_q, state_d;
    logic [AWIDTH-1:0] adr_q, adr_d, haddr_q, haddr_d;
    logic [DWIDTH-1:0] wdat_q, wdat_d, hwdata_q, hwdata_d, dat_o_q, dat_o_d;
    logic [2:0]        size_q, size_d, hsize_q, hsize_d, sz;
    logic [1:0]        htrans_q, htrans_d, off;
    logic              we_q, we_d, hwrite_q, hwrite_d, hbusreq_q, hbusreq_d;
    logic              ack_q, ack_d, err_q, err_d, legal;
    logic              unused_adr;
    // The byte offset comes from sel_i, so the WB low address bits carry no information
    assign unused_adr = ^adr_i[1:0];
    always_comb begin
        legal = 1'b1;
        sz    = 3'b000;
        off   = 2'd0;
        case (sel_i)
            4'b0001: off = 2'd0;
            4'b0010: off = 2'd1;
            4'b0100: off = 2'd2;
            4'b1000: off = 2'd3;
            4'b0011: sz = 3'b001;
            4'b1100: begin sz = 3'b001; off = 2'd2; end
            4'b1111: sz = 3'b010;
            default: legal = 1'b0;
        endcase
    end
    always_comb begin
        state_d   = state_q;
        adr_d     = adr_q;
        wdat_d    = wdat_q;
        size_d    = size_q;
        we_d      = we_q;
        haddr_d   = haddr_q;
        hsize_d   = hsize_q;
        hwrite_d  = hwrite_q;
        hwdata_d  = hwdata_q;
        dat_o_d   = dat_o_q;
        htrans_d  = htrans_q;
        hbusreq_d = hbusreq_q;
        ack_d     = 1'b0;
        err_d     = 1'b0;
        case (state_q)
            IDLE: if (cyc_i && stb_i) begin
                adr_d     = {adr_i[AWIDTH-1:2], off};
                wdat_d    = dat_i;
                size_d    = sz;
                we_d      = we_i;
                state_d   = legal ? REQ : ERR;
                hbusreq_d = legal;
                err_d     = !legal;
            end
            REQ: if (hgrant && hready) begin
                state_d  = ADDR;
                htrans_d = 2'b10;
                haddr_d  = adr_q;
                hsize_d  = size_q;
                hwrite_d = we_q;
            end
            // Address phase is only left on hready, even if the grant drops meanwhile
            ADDR: if (hready) begin
                state_d   = DATA;
                htrans_d  = 2'b00;
                hbusreq_d = 1'b0;
                hwdata_d  = we_q ? wdat_q : hwdata_q;
            end
            // Two-cycle responses are resolved on their hready-high cycle only
            DATA: if (hready) begin
                case (hresp)
                    2'b00: begin
                        state_d = ACK;
                        ack_d   = 1'b1;
                        dat_o_d = we_q ? dat_o_q : hrdata;
                    end
                    2'b01: begin
                        state_d = ERR;
                        err_d   = 1'b1;
                    end
                    default: begin
                        state_d   = REQ;
                        hbusreq_d = 1'b1;
                    end
                endcase
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            adr_q     <= '0;
            wdat_q    <= '0;
            size_q    <= '0;
            we_q      <= 1'b0;
            haddr_q   <= '0;
            hsize_q   <= '0;
            hwrite_q  <= 1'b0;
            hwdata_q  <= '0;
            dat_o_q   <= '0;
            htrans_q  <= 2'b00;
            hbusreq_q <= 1'b0;
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            adr_q     <= adr_d;
            wdat_q    <= wdat_d;
            size_q    <= size_d;
            we_q      <= we_d;
            haddr_q   <= haddr_d;
            hsize_q   <= hsize_d;
            hwrite_q  <= hwrite_d;
            hwdata_q  <= hwdata_d;
            dat_o_q   <= dat_o_d;
            htrans_q  <= htrans_d;
            hbusreq_q <= hbusreq_d;
            ack_q     <= ack_d;
            err_q     <= err_d;
        end
    end
    assign dat_o   = dat_o_q;
    assign ack_o   = ack_q;
    assign err_o   = err_q;
    assign hbusreq = hbusreq_q;
    assign haddr   = haddr_q;
    assign htrans  = htrans_q;
    assign hwrite  = hwrite_q;
    assign hsize   = hsize_q;
    assign hwdata  = hwdata_q;
    assign hburst  = 3'b000;
    assign hprot   = 4'b0011;
endmodule
